div_issue_ctrl: RTL

Issue/retire controller between the CPU execute stage and the 32-bit iterative unsigned divider core (start/busy interface, quotient/remainder outputs).
- Accepts DIV/DIVU requests and converts signed operands to magnitudes.
- Launches the core, waits for it to finish, then applies sign fix-up and writes the architectural HI (remainder) / LO (quotient) registers.
- Holds the pipeline stall while an operation is in flight, and handles divide-by-zero, flush and MTHI/MTLO.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_issue_ctrl_sign_fix.sv | 12 +
 rtl/div_issue_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divide issue/retire controller.
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    FIX       = 3'd4,
    DRAIN     = 3'd5
  } div_state_e;

endpackage

// File: rtl/div_issue_ctrl_sign_fix.sv
// Conditional two's-complement negate: magnitude extraction and result sign fix-up.
module sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result_c
);

  assign result_c = negate ? (~value) + WIDTH'(1) : value;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/retire controller for an iterative unsigned divider: operand
// conditioning, launch, completion wait, sign fix-up and HI/LO ownership.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  output logic             req_ready,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hilo_valid,
  output logic             div0,
  output logic             stall
);

  div_state_e       state, next_state;
  logic             sign_a, sign_b, zero_div;
  logic             in_idle, accept;
  logic [WIDTH-1:0] mag_a, mag_b, res_q, res_r, r_src;

  assign in_idle = (state == IDLE);
  assign accept  = req_valid & in_idle;

  sign_fix #(.WIDTH(WIDTH)) u_mag_a (
    .value(req_dividend), .negate(req_signed & req_dividend[WIDTH-1]), .result_c(mag_a)
  );
  sign_fix #(.WIDTH(WIDTH)) u_mag_b (
    .value(req_divisor), .negate(req_signed & req_divisor[WIDTH-1]), .result_c(mag_b)
  );

  // On divide-by-zero HI gets the original dividend back, rebuilt from its magnitude.
  assign r_src = zero_div ? div_dividend : div_r;

  sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .value(div_q), .negate(sign_a ^ sign_b), .result_c(res_q)
  );
  sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .value(r_src), .negate(sign_a), .result_c(res_r)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept) next_state = (req_divisor == '0) ? FIX : LAUNCH;
      LAUNCH:    next_state = flush ? DRAIN : WAIT_BUSY;
      WAIT_BUSY: if (flush) next_state = DRAIN;
                 else if (div_busy) next_state = RUN;
      RUN:       if (flush) next_state = DRAIN;
                 else if (!div_busy) next_state = FIX;
      FIX:       next_state = IDLE;
      DRAIN:     if (!div_busy) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Registered outputs, operand latches and architectural HI/LO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi           <= '0;
      lo           <= '0;
      hilo_valid   <= 1'b0;
      div0         <= 1'b0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      req_ready    <= 1'b1;
      stall        <= 1'b0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      zero_div     <= 1'b0;
    end else begin
      div_start  <= in_idle && (next_state == LAUNCH);
      hilo_valid <= (state == FIX);
      req_ready  <= (next_state == IDLE);
      stall      <= (next_state != IDLE);
      if (in_idle) begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
      end
      if (accept) begin
        sign_a       <= req_signed & req_dividend[WIDTH-1];
        sign_b       <= req_signed & req_divisor[WIDTH-1];
        zero_div     <= (req_divisor == '0);
        div_dividend <= mag_a;
        div_divisor  <= mag_b;
        div0         <= 1'b0;
      end
      if (state == FIX) begin
        hi   <= res_r;
        lo   <= zero_div ? WIDTH'(DIV0_QUOTIENT) : res_q;
        div0 <= zero_div;
      end
    end
  end

endmodule
